// File: rtl/psum_accumulator.sv
// Accumulates ACC_LEN PE-column psums, adds bias, rounds/shifts, saturates to DATA_BW; PSUM_ACC_RELU_EN clamps negatives to 0.
// Latency: result registered 1 cycle after the final beat is accepted.
// Backpressure: o_ready = !o_valid || i_ready; a held result stalls the input side.
module psum_accumulator #(
  parameter int SUM_BW   = 16,
  parameter int DATA_BW  = 8,
  parameter int ACC_BW   = 24,
  parameter int BIAS_BW  = 16,
  parameter int ACC_LEN  = 3,
  parameter int SHIFT_BW = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic signed [SUM_BW:0]     i_psum,
  input  logic signed [BIAS_BW-1:0]  i_bias,
  input  logic        [SHIFT_BW-1:0] i_shift,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [DATA_BW-1:0]  o_data,
  output logic                       o_busy
);

  localparam int CNT_BW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int RQ_BW  = ACC_BW + 2;
  localparam logic signed [RQ_BW-1:0] SAT_MAX = (RQ_BW'(1) << (DATA_BW - 1)) - RQ_BW'(1);
  localparam logic signed [RQ_BW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_BW-1:0]  acc;
  logic        [CNT_BW-1:0]  cnt;
  logic                      accept;
  logic                      final_beat;
  logic signed [ACC_BW-1:0]  psum_ext;
  logic signed [ACC_BW-1:0]  bias_ext;
  logic signed [ACC_BW-1:0]  sum;
  logic signed [RQ_BW-1:0]   sum_wide;
  logic signed [RQ_BW-1:0]   rnd;
  logic signed [RQ_BW-1:0]   rq;
  logic signed [DATA_BW-1:0] sat;
  logic signed [DATA_BW-1:0] res;

  assign o_ready    = !o_valid || i_ready;
  assign accept     = i_valid && o_ready;
  assign final_beat = (cnt == CNT_BW'(ACC_LEN - 1));
  assign o_busy     = (cnt != '0);

  always_comb begin
    psum_ext = ACC_BW'(i_psum);
    bias_ext = ACC_BW'(i_bias);
    sum      = acc + psum_ext + bias_ext;
    sum_wide = RQ_BW'(sum);
    rnd      = (i_shift == '0) ? '0 : (RQ_BW'(1) << (i_shift - SHIFT_BW'(1)));
    // Shifts wider than the accumulator always round to zero; avoids an oversized rounding constant.
    if (int'(i_shift) > ACC_BW) rq = '0;
    else                        rq = (sum_wide + rnd) >>> i_shift;

    if (rq > SAT_MAX)      sat = DATA_BW'(SAT_MAX);
    else if (rq < SAT_MIN) sat = DATA_BW'(SAT_MIN);
    else                   sat = rq[DATA_BW-1:0];

`ifdef PSUM_ACC_RELU_EN
    res = sat[DATA_BW-1] ? '0 : sat;
`else
    res = sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_clear) begin
      acc     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
    end else begin
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (accept) begin
        if (final_beat) begin
          acc     <= '0;
          cnt     <= '0;
          o_data  <= res;
          o_valid <= 1'b1;
        end else begin
          acc <= acc + psum_ext;
          cnt <= cnt + CNT_BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator (ACC_LEN=3 main instance, ACC_LEN=1 instance for streaming).
module tb_psum_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  logic i_clear, i_valid, i_ready;
  logic signed [16:0] i_psum;
  logic signed [15:0] i_bias;
  logic [4:0] i_shift;
  logic o_ready, o_valid, o_busy;
  logic signed [7:0] o_data;
  logic o_ready1, o_valid1, o_busy1;
  logic signed [7:0] o_data1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.SUM_BW(16), .DATA_BW(8), .ACC_BW(24), .BIAS_BW(16), .ACC_LEN(3), .SHIFT_BW(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready),
    .i_psum(i_psum), .i_bias(i_bias), .i_shift(i_shift), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_busy(o_busy)
  );

  psum_accumulator #(.SUM_BW(16), .DATA_BW(8), .ACC_BW(24), .BIAS_BW(16), .ACC_LEN(1), .SHIFT_BW(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready1),
    .i_psum(i_psum), .i_bias(i_bias), .i_shift(i_shift), .o_valid(o_valid1),
    .i_ready(i_ready), .o_data(o_data1), .o_busy(o_busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x);
    i_valid = 1'b1;
    i_psum  = 17'(x);
    tick();
  endtask

  task automatic run_group(input int a, input int b, input int c, input int bias, input int shift,
                           output logic v, output logic signed [7:0] d);
    i_bias  = 16'(bias);
    i_shift = 5'(shift);
    i_ready = 1'b1;
    send(a);
    send(b);
    send(c);
    v = o_valid;
    d = o_data;
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_psum = '0; i_bias = '0; i_shift = '0;
    #3;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %0b want 0", o_valid); end
    n_cmp++; if (o_data !== 8'sd0) begin n_fail++; $display("FAIL reset_o_data got %0d want 0", o_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_o_busy got %0b want 0", o_busy); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready got %0b want 1", o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    i_ready = 1'b1; i_bias = '0; i_shift = '0;
    send(10);
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy1 got %0b want 1", o_busy); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early got %0b want 0", o_valid); end
    send(20);
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy2 got %0b want 1", o_busy); end
    send(30);
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", o_valid); end
    n_cmp++; if (o_data !== 8'sd60) begin n_fail++; $display("FAIL basic_data got %0d want 60", o_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done got %0b want 0", o_busy); end
    i_valid = 1'b0;
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %0b want 0", o_valid); end
  endtask

  task automatic test_bias_round();
    logic v;
    logic signed [7:0] d;
    run_group(2, 2, 2, 1, 1, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 8'sd4) begin n_fail++; $display("FAIL round_pos got v=%0b d=%0d want v=1 d=4", v, d); end
    run_group(-3, -3, -2, 0, 1, v, d);
    n_cmp++; if (v !== 1'b1 || d !== -8'sd4) begin n_fail++; $display("FAIL round_neg_even got v=%0b d=%0d want v=1 d=-4", v, d); end
    run_group(-3, -2, -2, 0, 1, v, d);
    n_cmp++; if (v !== 1'b1 || d !== -8'sd3) begin n_fail++; $display("FAIL round_neg_half got v=%0b d=%0d want v=1 d=-3", v, d); end
    run_group(5, 0, 0, 1, 2, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 8'sd2) begin n_fail++; $display("FAIL round_shift2 got v=%0b d=%0d want v=1 d=2", v, d); end
  endtask

  task automatic test_saturation();
    logic v;
    logic signed [7:0] d;
    logic signed [7:0] neg_exp;
`ifdef PSUM_ACC_RELU_EN
    neg_exp = 8'sd0;
`else
    neg_exp = -8'sd128;
`endif
    run_group(100, 100, 100, 0, 0, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 8'sd127) begin n_fail++; $display("FAIL sat_pos got v=%0b d=%0d want v=1 d=127", v, d); end
    run_group(-100, -100, -100, 0, 0, v, d);
    n_cmp++; if (v !== 1'b1 || d !== neg_exp) begin n_fail++; $display("FAIL sat_neg got v=%0b d=%0d want v=1 d=%0d", v, d, neg_exp); end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b1; i_bias = '0; i_shift = '0;
    send(1); send(2); send(3);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_psum  = 17'sd4;
    #1;
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %0b want 0", o_ready); end
    repeat (3) tick();
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 8'sd6) begin n_fail++; $display("FAIL bp_hold got v=%0b d=%0d want v=1 d=6", o_valid, o_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept got busy=%0b want 0", o_busy); end
    i_ready = 1'b1;
    send(4);
    n_cmp++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%0b busy=%0b want v=0 busy=1", o_valid, o_busy); end
    send(5); send(6);
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 8'sd15) begin n_fail++; $display("FAIL bp_group2 got v=%0b d=%0d want v=1 d=15", o_valid, o_data); end
    send(7); send(8); send(9);
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 8'sd24) begin n_fail++; $display("FAIL bp_group3 got v=%0b d=%0d want v=1 d=24", o_valid, o_data); end
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1; i_valid = 1'b0; i_bias = '0; i_shift = '0;
    tick();
    send(5);
    n_cmp++; if (o_valid1 !== 1'b1 || o_data1 !== 8'sd5) begin n_fail++; $display("FAIL b2b_0 got v=%0b d=%0d want v=1 d=5", o_valid1, o_data1); end
    send(-7);
    n_cmp++; if (o_valid1 !== 1'b1 || o_data1 !== -8'sd7) begin n_fail++; $display("FAIL b2b_1 got v=%0b d=%0d want v=1 d=-7", o_valid1, o_data1); end
    send(200);
    n_cmp++; if (o_valid1 !== 1'b1 || o_data1 !== 8'sd127) begin n_fail++; $display("FAIL b2b_2 got v=%0b d=%0d want v=1 d=127", o_valid1, o_data1); end
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 8'sd127) begin n_fail++; $display("FAIL b2b_main got v=%0b d=%0d want v=1 d=127", o_valid, o_data); end
    i_valid = 1'b0;
    tick();
    n_cmp++; if (o_valid1 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", o_valid1); end
  endtask

  task automatic test_clear();
    logic v;
    logic signed [7:0] d;
    i_ready = 1'b1; i_bias = '0; i_shift = '0;
    send(5); send(5);
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_pre got %0b want 1", o_busy); end
    i_clear = 1'b1;
    send(9);
    i_clear = 1'b0;
    i_valid = 1'b0;
    n_cmp++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL clr_mid got busy=%0b v=%0b want 0 0", o_busy, o_valid); end
    run_group(1, 1, 1, 0, 0, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 8'sd3) begin n_fail++; $display("FAIL clr_next got v=%0b d=%0d want v=1 d=3", v, d); end
    send(2); send(2); send(2);
    i_valid = 1'b0;
    i_ready = 1'b0;
    tick();
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL clr_pending_pre got %0b want 1", o_valid); end
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL clr_pending got v=%0b rdy=%0b want 0 1", o_valid, o_ready); end
    i_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    logic v;
    logic signed [7:0] d;
    i_ready = 1'b1; i_bias = '0; i_shift = '0;
    send(1); send(2);
    i_valid = 1'b0;
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL arst_busy_pre got %0b want 1", o_busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (o_busy !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL arst_midgroup got busy=%0b rdy=%0b want 0 1", o_busy, o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(1); send(1); send(1);
    i_valid = 1'b0;
    i_ready = 1'b0;
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 8'sd3) begin n_fail++; $display("FAIL arst_pending_pre got v=%0b d=%0d want v=1 d=3", o_valid, o_data); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_data !== 8'sd0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL arst_pending got v=%0b d=%0d rdy=%0b want 0 0 1", o_valid, o_data, o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    run_group(2, 3, 4, 0, 0, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 8'sd9) begin n_fail++; $display("FAIL arst_next got v=%0b d=%0d want v=1 d=9", v, d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_round();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
